// File: rtl/coderom_loader_pkg.sv
//============================================================================
// Module  : coderom_loader_pkg
// Brief   : Shared geometry, FSM encodings and bank indices for the loader.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

package coderom_loader_pkg;

   localparam int CODEROM_AW   = 13;
   localparam int CODEROM_NIMG = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_CKSUM = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Bit positions in wr_sel; stream image index equals bank index.
   localparam int ROM0L = 0;
   localparam int ROM0H = 1;
   localparam int ROM1L = 2;
   localparam int ROM1H = 3;
   localparam int ROM2L = 4;
   localparam int ROM2H = 5;
   localparam int ROM3L = 6;
   localparam int ROM3H = 7;

endpackage

`default_nettype wire

// File: rtl/coderom_loader_if.sv
//============================================================================
// Module  : coderom_loader_if
// Brief   : Host byte stream plus bank write bus of the code ROM loader.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

interface coderom_loader_if
   import coderom_loader_pkg::*;
#(
   parameter int AW   = CODEROM_AW,
   parameter int DW   = 8,
   parameter int NIMG = CODEROM_NIMG
);
   logic [DW-1:0]   in_data;
   logic            in_valid;
   logic            in_ready;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [DW-1:0]   wr_data;
   logic [NIMG-1:0] wr_sel;

   modport master (
      output in_data, in_valid,
      input  in_ready, wr_en, wr_addr, wr_data, wr_sel
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, wr_en, wr_addr, wr_data, wr_sel
   );
endinterface

`default_nettype wire

// File: rtl/coderom_loader_cksum.sv
//============================================================================
// Module  : coderom_loader_cksum
// Brief   : Modulo-2^DW byte accumulator with clear, add and compare.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module coderom_loader_cksum #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr_i,
   input  logic          add_i,
   input  logic [DW-1:0] data_i,
   output logic          match_o
);
   logic [DW-1:0] sum_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum_q <= '0;
      end else if (clr_i) begin
         sum_q <= '0;
      end else if (add_i) begin
         sum_q <= sum_q + data_i;
      end
   end

   assign match_o = (sum_q == data_i);
endmodule

`default_nettype wire

// File: rtl/coderom_loader.sv
//============================================================================
// Module  : coderom_loader
// Brief   : Fills the eight code ROM byte banks from a host byte stream and
//           holds the CPU in reset until the last write has landed.
//           Optional per-image checksum: CODEROM_LOADER_CKSUM_EN.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module coderom_loader
   import coderom_loader_pkg::*;
#(
   parameter int AW   = CODEROM_AW,
   parameter int NIMG = CODEROM_NIMG,
   parameter int DW   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   coderom_loader_if.slave  bus,
   output logic             cpu_hold_o,
   output logic             done_o,
   output logic             err_o
);
   localparam int            IW        = (NIMG > 1) ? $clog2(NIMG) : 1;
   localparam logic [AW-1:0] ADDR_LAST = '1;
   localparam logic [IW-1:0] IMG_LAST  = IW'(NIMG - 1);

   logic [1:0]      state_q,    state_d;
   logic [AW-1:0]   addr_q,     addr_d;
   logic [IW-1:0]   img_q,      img_d;
   logic            wr_en_q,    wr_en_d;
   logic [AW-1:0]   wr_addr_q,  wr_addr_d;
   logic [DW-1:0]   wr_data_q,  wr_data_d;
   logic [NIMG-1:0] wr_sel_q,   wr_sel_d;
   logic            cpu_hold_q, cpu_hold_d;
   logic            done_q,     done_d;
   logic            accept;
   logic            last_byte;
   logic            restart;

   assign bus.in_ready = (state_q == ST_LOAD) || (state_q == ST_CKSUM);
   assign accept       = bus.in_valid && bus.in_ready;
   assign last_byte    = (addr_q == ADDR_LAST);
   assign restart      = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      img_d      = img_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      wr_sel_d   = wr_sel_q;
      cpu_hold_d = cpu_hold_q;
      done_d     = done_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_LOAD;
               addr_d  = '0;
               img_d   = '0;
            end
         end
         ST_LOAD: begin
            if (accept) begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = bus.in_data;
               wr_sel_d  = NIMG'(1) << img_q;
               addr_d    = addr_q + AW'(1);
               if (last_byte) begin
`ifdef CODEROM_LOADER_CKSUM_EN
                  state_d = ST_CKSUM;
`else
                  if (img_q == IMG_LAST) begin
                     state_d = ST_DONE;
                  end else begin
                     img_d = img_q + IW'(1);
                  end
`endif
               end
            end
         end
`ifdef CODEROM_LOADER_CKSUM_EN
         ST_CKSUM: begin
            if (accept) begin
               if (img_q == IMG_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_LOAD;
                  img_d   = img_q + IW'(1);
               end
            end
         end
`endif
         ST_DONE: begin
            // done rises one cycle after entry, i.e. after the final wr_en cycle.
            if (start_i) begin
               state_d    = ST_LOAD;
               addr_d     = '0;
               img_d      = '0;
               done_d     = 1'b0;
               cpu_hold_d = 1'b1;
            end else begin
               done_d     = 1'b1;
               cpu_hold_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         img_q      <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_sel_q   <= '0;
         cpu_hold_q <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         img_q      <= img_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         wr_sel_q   <= wr_sel_d;
         cpu_hold_q <= cpu_hold_d;
         done_q     <= done_d;
      end
   end

`ifdef CODEROM_LOADER_CKSUM_EN
   logic cks_clr;
   logic cks_match;
   logic err_q, err_d;

   assign cks_clr = restart || ((state_q == ST_CKSUM) && accept);

   coderom_loader_cksum #(.DW(DW)) u_cksum (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (cks_clr),
      .add_i   ((state_q == ST_LOAD) && accept),
      .data_i  (bus.in_data),
      .match_o (cks_match)
   );

   always_comb begin
      err_d = err_q;
      if (restart) begin
         err_d = 1'b0;
      end else if ((state_q == ST_CKSUM) && accept && !cks_match) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign bus.wr_sel  = wr_sel_q;
   assign cpu_hold_o  = cpu_hold_q;
   assign done_o      = done_q;
endmodule

`default_nettype wire

// File: tb/tb_coderom_loader.sv
//============================================================================
// Module  : tb_coderom_loader
// Brief   : Directed self-checking bench for coderom_loader, reduced image
//           size (AW=10) so several complete loads fit a short run.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_coderom_loader;
   import coderom_loader_pkg::*;

   localparam int AW     = 10;
   localparam int NIMG   = CODEROM_NIMG;
   localparam int DW     = 8;
   localparam int IMG_SZ = 1 << AW;
   localparam int TOTAL  = NIMG * IMG_SZ;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic cpu_hold, done, err;

   coderom_loader_if #(.AW(AW), .DW(DW), .NIMG(NIMG)) bus ();

   coderom_loader #(.AW(AW), .NIMG(NIMG), .DW(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start_i    (start),
      .bus        (bus),
      .cpu_hold_o (cpu_hold),
      .done_o     (done),
      .err_o      (err)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total_cnt = 0;
   int wr_count = 0;
   int pipe_err = 0;
   int sel_err = 0;
   int timeouts = 0;
   logic       tb_cks = 1'b0;
   logic       acc_prev = 1'b0;
   logic [7:0] acc_data = 8'h00;
   logic [7:0] exp_mem [TOTAL];
   logic [7:0] mdl [TOTAL];

   // Bank model and write-latency monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (reset) begin
         acc_prev = 1'b0;
      end else begin
         if (bus.wr_en !== acc_prev) pipe_err++;
         if (bus.wr_en === 1'b1) begin
            wr_count++;
            if (bus.wr_data !== acc_data) pipe_err++;
            if ($countones(bus.wr_sel) != 1) sel_err++;
            for (int b = 0; b < NIMG; b++)
               if (bus.wr_sel[b]) mdl[b*IMG_SZ + int'(bus.wr_addr)] = bus.wr_data;
         end
         acc_prev = bus.in_valid & bus.in_ready & ~tb_cks;
         acc_data = bus.in_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   function automatic logic [7:0] pattern(input int i, input int seed);
      if (seed == 0 && i == 0) return 8'h01;
      if (seed == 0 && i == 1) return 8'h75;
      return 8'((i * 13) + ((i >> 8) * 7) + (seed * 29) + 3);
   endfunction

   task automatic send_byte(input logic [7:0] d, input logic cks);
      bit ok = 0;
      tb_cks = cks;
      bus.in_data = d;
      bus.in_valid = 1'b1;
      for (int n = 0; n < 32 && !ok; n++) begin
         if (bus.in_ready === 1'b1) ok = 1;
         tick();
      end
      bus.in_valid = 1'b0;
      tb_cks = 1'b0;
      if (!ok) timeouts++;
   endtask

   task automatic send_cks(input int img, input int corrupt);
      logic [7:0] s = 8'h00;
      for (int a = 0; a < IMG_SZ; a++) s = s + exp_mem[img*IMG_SZ + a];
      send_byte(s + 8'(corrupt), 1'b1);
   endtask

   task automatic run_load(input int from, input int upto, input bit gaps,
                           input int seed, input int bad_img);
      logic [7:0] d;
      for (int i = from; i < upto && timeouts == 0; i++) begin
         if (gaps) begin
            while ($urandom_range(0, 3) == 0) begin
               bus.in_data = 8'($urandom);
               tick();
            end
         end
         d = pattern(i, seed);
         exp_mem[i] = d;
         send_byte(d, 1'b0);
`ifdef CODEROM_LOADER_CKSUM_EN
         if ((i % IMG_SZ) == IMG_SZ - 1 && i != TOTAL - 1)
            send_cks(i / IMG_SZ, (i / IMG_SZ) == bad_img ? 1 : 0);
`endif
      end
   endtask

   task automatic finish_load(input int bad_img);
`ifdef CODEROM_LOADER_CKSUM_EN
      send_cks(NIMG - 1, (bad_img == NIMG - 1) ? 1 : 0);
`endif
      if (bad_img < -1) $display("unused %0d", bad_img);
   endtask

   task automatic wait_done(input string tag);
      bit ok = 0;
      for (int n = 0; n < 16 && !ok; n++) begin
         if (done === 1'b1) ok = 1;
         else tick();
      end
      check(tag, 32'(ok), 32'd1);
   endtask

   task automatic check_banks(input string tag);
      int bad = 0;
      for (int i = 0; i < TOTAL; i++) if (mdl[i] !== exp_mem[i]) bad++;
      check(tag, bad, 0);
   endtask

   initial begin
      int base;
      int p0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      // 1. reset state and idle streaming
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      check("rst_done",     32'(done), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_wr_en",    32'(bus.wr_en), 32'd0);
      check("rst_wr_addr",  32'(bus.wr_addr), 32'd0);
      check("rst_wr_data",  32'(bus.wr_data), 32'd0);
      check("rst_wr_sel",   32'(bus.wr_sel), 32'd0);
      check("rst_err",      32'(err), 32'd0);
      base = wr_count;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA5;
      repeat (5) tick();
      bus.in_valid = 1'b0;
      check("idle_no_writes", 32'(wr_count - base), 32'd0);
      check("idle_cpu_hold",  32'(cpu_hold), 32'd1);
      check("idle_in_ready",  32'(bus.in_ready), 32'd0);

      // 2. first two bytes, written one cycle after accept
      pulse_start();
      check("load_in_ready", 32'(bus.in_ready), 32'd1);
      base = wr_count;
      p0 = pipe_err;
      run_load(0, 1, 0, 0, -1);
      check("wr0_en",   32'(bus.wr_en), 32'd1);
      check("wr0_sel",  32'(bus.wr_sel), 32'h01);
      check("wr0_addr", 32'(bus.wr_addr), 32'd0);
      check("wr0_data", 32'(bus.wr_data), 32'h01);
      run_load(1, 2, 0, 0, -1);
      check("wr1_sel",  32'(bus.wr_sel), 32'h01);
      check("wr1_addr", 32'(bus.wr_addr), 32'd1);
      check("wr1_data", 32'(bus.wr_data), 32'h75);

      // 3. image wrap, ignored start, final write and release timing
      run_load(2, IMG_SZ + 1, 0, 0, -1);
      check("wrap_sel",  32'(bus.wr_sel), 32'h02);
      check("wrap_addr", 32'(bus.wr_addr), 32'd0);
      pulse_start();
      check("start_in_load_ignored", 32'(bus.in_ready), 32'd1);
      run_load(IMG_SZ + 1, TOTAL, 0, 0, -1);
      check("last_wr_en",   32'(bus.wr_en), 32'd1);
      check("last_sel",     32'(bus.wr_sel), 32'h80);
      check("last_addr",    32'(bus.wr_addr), 32'(IMG_SZ - 1));
      check("last_done",    32'(done), 32'd0);
      check("last_cpu_hold", 32'(cpu_hold), 32'd1);
`ifdef CODEROM_LOADER_CKSUM_EN
      finish_load(-1);
      tick();
`else
      tick();
`endif
      check("fin_done",     32'(done), 32'd1);
      check("fin_cpu_hold", 32'(cpu_hold), 32'd0);
      check("fin_wr_en",    32'(bus.wr_en), 32'd0);
      check("fin_in_ready", 32'(bus.in_ready), 32'd0);
      check("load1_count",  32'(wr_count - base), 32'(TOTAL));
      check("load1_pipe",   32'(pipe_err - p0), 32'd0);
      check_banks("load1_banks");
      check("err_clean", 32'(err), 32'd0);

      // 4. restart from DONE, randomly gapped stream
      pulse_start();
      check("restart_done",     32'(done), 32'd0);
      check("restart_cpu_hold", 32'(cpu_hold), 32'd1);
      base = wr_count;
      p0 = pipe_err;
      run_load(0, TOTAL, 1, 1, 2);
      finish_load(2);
      wait_done("load2_done");
      check("load2_cpu_hold", 32'(cpu_hold), 32'd0);
      check("load2_count",    32'(wr_count - base), 32'(TOTAL));
      check("load2_pipe",     32'(pipe_err - p0), 32'd0);
      check_banks("load2_banks");
`ifdef CODEROM_LOADER_CKSUM_EN
      check("err_bad_cksum", 32'(err), 32'd1);
`endif

      // 5. reset in the middle of a load, then a full reload
      pulse_start();
      run_load(0, 3000, 0, 2, -1);
      reset = 1'b1;
      tick();
      check("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
      check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      check("midrst_wr_en",    32'(bus.wr_en), 32'd0);
      reset = 1'b0;
      tick();
      check("postrst_idle", 32'(bus.in_ready), 32'd0);
      check("postrst_err",  32'(err), 32'd0);
      pulse_start();
      base = wr_count;
      p0 = pipe_err;
      run_load(0, TOTAL, 1, 3, -1);
      finish_load(-1);
      wait_done("load3_done");
      check("load3_count", 32'(wr_count - base), 32'(TOTAL));
      check("load3_pipe",  32'(pipe_err - p0), 32'd0);
      check_banks("load3_banks");
      check("load3_err",   32'(err), 32'd0);
      check("sel_onehot",  32'(sel_err), 32'd0);
      check("accept_timeouts", 32'(timeouts), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

`default_nettype wire
